pipo_load_arbiter: RTL and testbench
====================================

// Module: pipo_load_arbiter
// PURPOSE
//   Shares one WIDTH-bit parallel-in/parallel-out holding register among NREQ requesters.
//   Round-robin arbitration selects one requester, whose word is loaded in one cycle.
//   The word is presented on q until the downstream consumer acknowledges it.
//   Sits between several producers and a single PIPO datapath stage.
// PARAMETERS
//   WIDTH  4  data width of each requester word and of q
//   NREQ   4  number of requesters (>=2, need not be a power of two)
// PORTS
//   clk      in   1           single clock, rising edge
//   rst      in   1           synchronous active-low reset
//   req      in   NREQ        req[i]=1: requester i has a word on din slice i
//   din      in   NREQ*WIDTH  requester i word = din[i*WIDTH +: WIDTH]
//   gnt      out  NREQ        registered one-hot pulse: word of requester i captured this edge
//   q        out  WIDTH       held register contents
//   q_valid  out  1           q holds a word not yet acknowledged
//   q_owner  out  clog2(NREQ) index of requester that loaded q
//   q_ack    in   1           consumer accepts q; sampled only while q_valid=1
// BEHAVIOUR
//   Reset (rst=0 at a clk edge): q=0, q_valid=0, q_owner=0, gnt=0, ptr=0, state=IDLE.
//     The reset overrides all other inputs, including in mid-HOLD.
//   The FSM has two states: IDLE (q_valid=0) and HOLD (q_valid=1).
//   Winner selection (combinational): scan req from index ptr upward, wrapping NREQ-1 -> 0.
//     The first set bit wins. If req==0, there is no winner.
//   Load event (at one clk edge):
//     q<=din[winner], q_owner<=winner, q_valid<=1, gnt<=onehot(winner).
//     ptr<=(winner==NREQ-1)?0:winner+1. state<=HOLD.
//   IDLE: a winner exists -> load event (latency 1 clk from req to q/gnt). No winner -> stay, gnt=0.
//   HOLD, q_ack=0: q, q_owner and q_valid stay stable. req is ignored. gnt=0.
//   HOLD, q_ack=1, winner exists: back-to-back load event in the same edge. q_valid stays 1.
//   HOLD, q_ack=1, no winner: q_valid<=0, state<=IDLE.
//     q and q_owner retain their last values (PIPO hold).
//   q_ack while in IDLE is ignored.
//   gnt is high for exactly one cycle per load. It is always one-hot or zero.
//   A requester may deassert req the cycle after its gnt. If req is kept high, the requester reloads
//     only after the other active requesters have been served (fairness, no starvation).
//   If req is deasserted before a grant, the request is dropped with no side effects.
// STRUCTURE
//   Shared package/include pipo_arb_pkg:
//     state encodings ST_IDLE=1'b0, ST_HOLD=1'b1
//     clog2 function used for the q_owner width
//   Sub-module rr_priority_pick (combinational): inputs req, ptr; outputs winner index and any_win.
//   Top level: FSM, ptr register, data mux, output registers.
// TESTING (WIDTH=4, NREQ=4)
//   1. rst=0 for 2 clk, then rst=1, req=0 -> q=0, q_valid=0, gnt=0 throughout.
//   2. req=4'b0001, din slice0=4'hf; q_ack=0 -> next edge q=4'hf, q_owner=0, gnt=4'b0001
//      for 1 cycle. q_valid holds at 1 while req changes.
//   3. req=4'b1111, slices {1,2,3}={8,4,2}, q_ack=1 every cycle after test 2 ->
//      loads from owners 1,2,3,0 in that order. q=8,4,2,then slice0. One gnt pulse each,
//      q_valid is never 0.
//   4. Wrap: ptr=3, req=4'b1001 -> owner 3 wins, then owner 0. req=4'b0000 with q_ack=1 ->
//      q_valid=0, q holds its last value.
//   5. In HOLD with q=4'h1, assert rst=0 for 1 edge -> q=0, q_valid=0, gnt=0.
//      After rst=1 with req=4'b0100, owner 2 is loaded (ptr restarts at 0).
//   6. In IDLE, q_ack=1 with req=0 for 3 cycles -> no state change, gnt=0.

Source files
------------

// File: rtl/pipo_load_arbiter_pkg.sv
// Shared types and helpers for the PIPO load arbiter.
// State encoding plus a constant log2 for index widths.
package pipo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipo_load_arbiter_if.sv
// Producer/consumer bundle around the shared PIPO register.
// master = bench/producers side, slave = arbiter side.
interface pipo_load_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  import pipo_arb_pkg::*;

  localparam int OW = clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic [OW-1:0]         q_owner;
  logic                  q_ack;

  modport master (
    output req, din, q_ack,
    input  gnt, q, q_valid, q_owner
  );

  modport slave (
    input  req, din, q_ack,
    output gnt, q, q_valid, q_owner
  );

endinterface

// File: rtl/pipo_load_arbiter_pick.sv
// Round-robin pick: first set req bit at or after ptr,
// wrapping NREQ-1 -> 0.
module rr_priority_pick
  import pipo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic [OW-1:0]   winner,
  output logic            any_win
);

  logic [OW:0] idx;

  // Scan from farthest to nearest so the nearest hit is written last
  always_comb begin
    winner  = '0;
    any_win = 1'b0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (OW + 1)'(k);
      if (idx >= (OW + 1)'(NREQ)) idx = idx - (OW + 1)'(NREQ);
      if (req[idx[OW-1:0]]) begin
        winner  = idx[OW-1:0];
        any_win = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin loader for one shared PIPO holding register.
// Word is held on q until the consumer acks it.
module pipo_load_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic clk,
  input  logic rst,
  pipo_load_arbiter_if.slave bus
);

  localparam int OW = clog2(NREQ);

  state_t            state, state_nx;
  logic [OW-1:0]     ptr, ptr_nx;
  logic [OW-1:0]     winner;
  logic              any_win;
  logic              load;
  logic [WIDTH-1:0]  din_sel;
  logic [NREQ-1:0]   gnt_nx;
  logic [WIDTH-1:0]  q_r;
  logic [OW-1:0]     owner_r;
  logic [NREQ-1:0]   gnt_r;

  rr_priority_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .winner  (winner),
    .any_win (any_win)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_win) begin
          load     = 1'b1;
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.q_ack) begin
          if (any_win) load = 1'b1;
          else state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    din_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (OW'(i) == winner) din_sel = bus.din[i*WIDTH +: WIDTH];
    end
  end

  assign gnt_nx = NREQ'(1) << winner;
  assign ptr_nx = (winner == OW'(NREQ - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      q_r     <= '0;
      owner_r <= '0;
      gnt_r   <= '0;
    end else begin
      state <= state_nx;
      gnt_r <= load ? gnt_nx : '0;
      // q/owner keep the last word even after returning to idle
      if (load) begin
        q_r     <= din_sel;
        owner_r <= winner;
        ptr     <= ptr_nx;
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.q_owner = owner_r;
  assign bus.gnt     = gnt_r;
  assign bus.q_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Bench for pipo_load_arbiter: vector table, hand sequences,
// then randomized traffic against a reference model.
module tb_pipo_load_arbiter;
  import pipo_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipo_load_arbiter_if #(.WIDTH(4), .NREQ(4)) bus ();

  pipo_load_arbiter #(
    .WIDTH (4),
    .NREQ  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        r;
    logic [3:0]  req;
    logic [15:0] din;
    logic        ack;
    logic [3:0]  q;
    logic        v;
    logic [1:0]  o;
    logic [3:0]  g;
  } vec_t;

  typedef struct packed {
    logic [3:0] q;
    logic       v;
    logic [1:0] o;
    logic [3:0] g;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int   pass_cnt = 0;
  int   total    = 0;

  logic       m_v;
  logic [1:0] m_ptr, m_o;
  logic [3:0] m_q;

  localparam logic [15:0] D0 = 16'h248f;
  localparam logic [15:0] D1 = 16'h241f;

  function automatic vec_t mk(input logic r, input logic [3:0] rq,
                              input logic [15:0] d, input logic a,
                              input logic [3:0] q, input logic v,
                              input logic [1:0] o, input logic [3:0] g);
    vec_t x;
    x.r = r; x.req = rq; x.din = d; x.ack = a;
    x.q = q; x.v = v; x.o = o; x.g = g;
    return x;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq,
                            input logic [15:0] d, input logic a,
                            output exp_t e);
    logic [7:0] dbl;
    int w;
    w = -1;
    e = '0;
    if (!r) begin
      m_v = 1'b0; m_ptr = '0; m_q = '0; m_o = '0;
      return;
    end
    dbl = {rq, rq} >> m_ptr;
    for (int i = 0; i < 4; i++)
      if (w < 0 && dbl[i]) w = (int'(m_ptr) + i) % 4;
    if ((!m_v || a) && w >= 0) begin
      m_q   = d[w*4 +: 4];
      m_o   = 2'(w);
      m_v   = 1'b1;
      m_ptr = 2'((w + 1) % 4);
      e.g   = 4'(1 << w);
    end else if (m_v && a) begin
      m_v = 1'b0;
    end
    e.q = m_q; e.v = m_v; e.o = m_o;
  endtask

  task automatic step(input logic r, input logic [3:0] rq,
                      input logic [15:0] d, input logic a,
                      input logic use_model, input exp_t e_tbl,
                      input string nm);
    exp_t em, e, act;
    @(negedge clk);
    rst = r; bus.req = rq; bus.din = d; bus.q_ack = a;
    model_step(r, rq, d, a, em);
    sbq.push_back(use_model ? em : e_tbl);
    @(posedge clk);
    #1;
    act = {bus.q, bus.q_valid, bus.q_owner, bus.gnt};
    total++;
    if (sbq.size() == 0) begin
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      if (act === e) pass_cnt++;
      else $display("FAIL %s: got q=%h v=%b o=%0d g=%b need q=%h v=%b o=%0d g=%b",
                    nm, act.q, act.v, act.o, act.g, e.q, e.v, e.o, e.g);
    end
  endtask

  task automatic hexp(input logic r, input logic [3:0] rq,
                      input logic [15:0] d, input logic a,
                      input logic [3:0] q, input logic v,
                      input logic [1:0] o, input logic [3:0] g,
                      input string nm);
    exp_t e;
    e = {q, v, o, g};
    step(r, rq, d, a, 1'b0, e, nm);
  endtask

  initial begin
    rst = 1'b0; bus.req = '0; bus.din = D0; bus.q_ack = 1'b0;
    m_v = 1'b0; m_ptr = '0; m_q = '0; m_o = '0;

    tbl.push_back(mk(0, 4'h0, D0, 0, 4'h0, 0, 0, 4'h0));
    tbl.push_back(mk(0, 4'h0, D0, 0, 4'h0, 0, 0, 4'h0));
    tbl.push_back(mk(1, 4'h0, D0, 0, 4'h0, 0, 0, 4'h0));
    tbl.push_back(mk(1, 4'h1, D0, 0, 4'hf, 1, 0, 4'h1));
    tbl.push_back(mk(1, 4'h0, D0, 0, 4'hf, 1, 0, 4'h0));
    tbl.push_back(mk(1, 4'he, D0, 0, 4'hf, 1, 0, 4'h0));
    tbl.push_back(mk(1, 4'hf, D0, 1, 4'h8, 1, 1, 4'h2));
    tbl.push_back(mk(1, 4'hf, D0, 1, 4'h4, 1, 2, 4'h4));
    tbl.push_back(mk(1, 4'hf, D0, 1, 4'h2, 1, 3, 4'h8));
    tbl.push_back(mk(1, 4'hf, D0, 1, 4'hf, 1, 0, 4'h1));
    tbl.push_back(mk(1, 4'h9, D0, 1, 4'h2, 1, 3, 4'h8));
    tbl.push_back(mk(1, 4'h9, D0, 1, 4'hf, 1, 0, 4'h1));
    tbl.push_back(mk(1, 4'h0, D0, 1, 4'hf, 0, 0, 4'h0));
    tbl.push_back(mk(1, 4'h0, D0, 1, 4'hf, 0, 0, 4'h0));
    tbl.push_back(mk(1, 4'h0, D0, 1, 4'hf, 0, 0, 4'h0));
    tbl.push_back(mk(1, 4'h0, D0, 1, 4'hf, 0, 0, 4'h0));
    tbl.push_back(mk(1, 4'h2, D1, 0, 4'h1, 1, 1, 4'h2));
    tbl.push_back(mk(1, 4'h2, D1, 0, 4'h1, 1, 1, 4'h0));
    tbl.push_back(mk(0, 4'h2, D1, 1, 4'h0, 0, 0, 4'h0));
    tbl.push_back(mk(1, 4'h4, D0, 0, 4'h4, 1, 2, 4'h4));
    tbl.push_back(mk(1, 4'h0, D0, 1, 4'h4, 0, 2, 4'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      e = {tbl[i].q, tbl[i].v, tbl[i].o, tbl[i].g};
      step(tbl[i].r, tbl[i].req, tbl[i].din, tbl[i].ack, 1'b0, e,
           $sformatf("vec%0d", i));
    end

    // Two persistent requesters must alternate
    hexp(0, 4'h3, D0, 1, 4'h0, 0, 0, 4'h0, "fair_rst");
    hexp(1, 4'h3, D0, 1, 4'hf, 1, 0, 4'h1, "fair0");
    hexp(1, 4'h3, D0, 1, 4'h8, 1, 1, 4'h2, "fair1");
    hexp(1, 4'h3, D0, 1, 4'hf, 1, 0, 4'h1, "fair2");
    hexp(1, 4'h3, D0, 1, 4'h8, 1, 1, 4'h2, "fair3");
    // Request withdrawn while another word is held: no trace
    hexp(1, 4'h4, D0, 0, 4'h8, 1, 1, 4'h0, "drop_hold");
    hexp(1, 4'h0, D0, 1, 4'h8, 0, 1, 4'h0, "drop_idle");
    hexp(1, 4'h8, D0, 0, 4'h2, 1, 3, 4'h8, "after_drop");

    for (int i = 0; i < 300; i++) begin
      logic r;
      r = ($urandom_range(0, 39) != 0);
      step(r, 4'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom_range(0, 1)), 1'b1, '0,
           $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
